// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// drives PC, register-file, ALU-mux and memory strobes, counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  input  logic             i_branch_taken,
  output logic             o_ir_we,
  output logic             o_imem_re,
  output logic             o_pc_we,
  output logic             o_oldpc_we,
  output logic             o_pc_src,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic             o_dmem_re,
  output logic             o_dmem_we,
  output logic             o_rf_we,
  output logic [1:0]       o_wb_sel,
  output logic             o_illegal,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_ILLEGAL = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } cls_t;

  state_t state, state_nx;
  cls_t   cls, dec_cls;
  logic   retire;

  // funct3 only matters to the ALU decoder downstream
  logic unused_funct3;
  assign unused_funct3 = ^i_funct3;

  always_comb begin
    dec_cls = C_BAD;
    case (i_opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      default:    dec_cls = C_BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state     <= S_FETCH;
      cls       <= C_R;
      o_instret <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE)
        cls <= dec_cls;
      if (retire)
        o_instret <= o_instret + CNT_W'(1);
    end
  end

  // Strobes are only produced while out of reset, so an aborted instruction writes nothing.
  always_comb begin
    state_nx    = state;
    retire      = 1'b0;
    o_ir_we     = 1'b0;
    o_imem_re   = 1'b0;
    o_pc_we     = 1'b0;
    o_oldpc_we  = 1'b0;
    o_pc_src    = 1'b0;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 2'b00;
    o_alu_op    = 2'b00;
    o_dmem_re   = 1'b0;
    o_dmem_we   = 1'b0;
    o_rf_we     = 1'b0;
    o_wb_sel    = 2'b00;
    if (i_rst) begin
      unique case (state)
        S_FETCH: begin
          o_imem_re = 1'b1;
          if (i_imem_ready) begin
            o_ir_we    = 1'b1;
            o_pc_we    = 1'b1;
            o_oldpc_we = 1'b1;
            state_nx   = S_DECODE;
          end
        end
        S_DECODE: begin
          state_nx = (dec_cls == C_BAD) ? S_ILLEGAL : S_EXECUTE;
        end
        S_EXECUTE: begin
          case (cls)
            C_R: begin
              o_alu_op = 2'b10;
              state_nx = S_WB;
            end
            C_I: begin
              o_alu_src_b = 2'b01;
              o_alu_op    = 2'b10;
              state_nx    = S_WB;
            end
            C_LOAD, C_STORE: begin
              o_alu_src_b = 2'b01;
              state_nx    = S_MEM;
            end
            C_BRANCH: begin
              o_alu_op = 2'b01;
              if (i_branch_taken) begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b01;
                o_pc_we     = 1'b1;
                o_pc_src    = 1'b1;
              end
              retire   = 1'b1;
              state_nx = S_FETCH;
            end
            C_JAL, C_JALR: begin
              o_alu_src_a = (cls == C_JAL);
              o_alu_src_b = 2'b01;
              o_pc_we     = 1'b1;
              o_pc_src    = 1'b1;
              o_rf_we     = 1'b1;
              o_wb_sel    = 2'b10;
              retire      = 1'b1;
              state_nx    = S_FETCH;
            end
            C_LUI: begin
              state_nx = S_WB;
            end
            C_AUIPC: begin
              o_alu_src_a = 1'b1;
              o_alu_src_b = 2'b01;
              state_nx    = S_WB;
            end
            default: state_nx = S_ILLEGAL;
          endcase
        end
        S_MEM: begin
          if (cls == C_LOAD)
            o_dmem_re = 1'b1;
          else
            o_dmem_we = 1'b1;
          if (i_dmem_ready) begin
            if (cls == C_LOAD) begin
              state_nx = S_WB;
            end else begin
              retire   = 1'b1;
              state_nx = S_FETCH;
            end
          end
        end
        S_WB: begin
          o_rf_we  = 1'b1;
          o_wb_sel = (cls == C_LOAD) ? 2'b01 : (cls == C_LUI) ? 2'b11 : 2'b00;
          retire   = 1'b1;
          state_nx = S_FETCH;
        end
        S_ILLEGAL: state_nx = S_ILLEGAL;
        default:   state_nx = S_FETCH;
      endcase
    end
  end

  assign o_illegal = (state == S_ILLEGAL);
  assign o_state   = state;

endmodule
